uart_tx_stream: RTL and testbench
=================================

UART_TX_STREAM -- requirements
Module: uart_tx_stream

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, line bit rate.
REQ-003 SHALL derive CLKS_PER_BIT = CLK_FREQ/BAUD, integer division; values below 2 are illegal and SHALL fail elaboration.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port fifo_empty  input  1  upstream FIFO holds no byte.
REQ-007 SHALL have port fifo_data  input  8  FIFO read data, valid the cycle after fifo_rd_en.
REQ-008 SHALL have port fifo_rd_en  output  1  single-cycle pop request to the FIFO.
REQ-009 SHALL have port TXD  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse after the last stop-bit cycle.

Function
REQ-012 SHALL implement states IDLE, LOAD, START, DATA, PARITY, STOP.
REQ-013 IDLE: TXD=1; if fifo_empty=0, SHALL assert fifo_rd_en for exactly one cycle and go to LOAD.
REQ-014 LOAD: SHALL capture fifo_data into the shift register and go to START.
REQ-015 START: SHALL drive TXD=0 for CLKS_PER_BIT cycles.
REQ-016 DATA: SHALL send 8 bits LSB first, each held CLKS_PER_BIT cycles; the bit index counts 0..7 and does not wrap.
REQ-017 STOP: SHALL drive TXD=1 for CLKS_PER_BIT cycles, pulse tx_done on the following cycle, and return to IDLE.
REQ-018 fifo_rd_en SHALL never assert while fifo_empty=1 or outside IDLE.
REQ-019 With back-to-back data, the start bit of the next frame SHALL begin exactly 2 cycles after the stop bit ends (IDLE + LOAD).
REQ-020 A fifo_empty change during a frame SHALL have no effect until IDLE.
REQ-021 The bit-period counter SHALL count 0..CLKS_PER_BIT-1, reset to 0 on every state change, and be sized $clog2(CLKS_PER_BIT).
REQ-022 TXD SHALL be driven from a register, with no combinational glitches.

Reset
REQ-023 While rst=1 at a clock edge: state=IDLE, TXD=1, fifo_rd_en=0, busy=0, tx_done=0, and counters and shift register cleared.
REQ-024 Reset mid-frame SHALL abort the frame with TXD=1 from the next cycle; the aborted byte is discarded and not re-popped.

Configuration
REQ-025 With UART_TX_PARITY_EN defined, DATA SHALL go to PARITY, which sends the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, then STOP.
REQ-026 Without UART_TX_PARITY_EN, PARITY SHALL be unreachable and DATA SHALL go directly to STOP (10-bit frame).

Structure
REQ-027 Package uart_pkg SHALL hold the state enum typedef, DATA_BITS=8, and the idle-level constant, shared with the receiver.
REQ-028 The bit-period timing SHALL live in one sub-module uart_baud_cnt (parameter CLKS_PER_BIT, inputs clear, outputs bit_end).

Verification (CLK_FREQ=50_000_000, BAUD=5_000_000, so CLKS_PER_BIT=10)
REQ-029 Reset: hold rst 3 cycles with fifo_empty=0 -> TXD=1, fifo_rd_en=0, busy=0 throughout.
REQ-030 Single byte 0xA5 -> one rd_en pulse; TXD = 0,1,0,1,0,0,1,0,1,1 at 10 cycles each (100 cycles); tx_done pulse 1 cycle after the stop bit; busy low afterwards.
REQ-031 Back-to-back 0x00 then 0xFF -> exactly 2 TXD-high cycles between the first stop-bit end and the second start bit; exactly 2 rd_en pulses total.
REQ-032 rst asserted at cycle 45 of a frame -> TXD=1 next cycle; no tx_done; with FIFO empty afterwards, no further rd_en.
REQ-033 With UART_TX_PARITY_EN, byte 0x07 -> parity bit = 1 and frame length = 110 cycles; byte 0x03 -> parity bit = 0.
REQ-034 fifo_empty held 1 for 1000 cycles -> fifo_rd_en never asserts, TXD constantly 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and line idle level.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, flags the last cycle of each bit period.
// The clear input restarts the period at 0 on the next edge.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned       CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear || bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bit_end = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter draining an upstream FIFO: 8N1 frames, or 8E1 when the
// UART_TX_PARITY_EN macro is defined at build time.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd_en,
  output logic                 TXD,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_stream: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

  uart_state_e           r_state;
  uart_state_e           w_state_next;
  logic [DATA_BITS-1:0]  r_shift;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [IDX_W-1:0]      w_bit_idx_next;
  logic                  r_txd;
  logic                  w_txd_next;
  logic                  r_tx_done;
  logic                  w_bit_end;
  logic                  w_clear;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_clear),
    .bit_end(w_bit_end)
  );

  always_comb begin
    w_state_next   = r_state;
    w_bit_idx_next = r_bit_idx;
    case (r_state)
      IDLE:   if (!fifo_empty) w_state_next = LOAD;
      LOAD: begin
        w_state_next   = START;
        w_bit_idx_next = '0;
      end
      START:  if (w_bit_end) w_state_next = DATA;
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end else begin
            w_bit_idx_next = r_bit_idx + IDX_W'(1);
          end
        end
      end
      PARITY: if (w_bit_end) w_state_next = STOP;
      STOP:   if (w_bit_end) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Line level is decoded from the next state so the registered TXD lines up with r_state.
  always_comb begin
    w_txd_next = IDLE_LEVEL;
    case (w_state_next)
      START:   w_txd_next = 1'b0;
      DATA:    w_txd_next = r_shift[w_bit_idx_next];
      PARITY:  w_txd_next = ^r_shift;
      default: w_txd_next = IDLE_LEVEL;
    endcase
  end

  assign w_clear = (w_state_next != r_state);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_txd     <= IDLE_LEVEL;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bit_idx <= w_bit_idx_next;
      r_txd     <= w_txd_next;
      r_tx_done <= (r_state == STOP) && w_bit_end;
      if (r_state == LOAD) r_shift <= fifo_data;
    end
  end

  assign fifo_rd_en = (r_state == IDLE) && !fifo_empty && !rst;
  assign busy       = (r_state != IDLE);
  assign TXD        = r_txd;
  assign tx_done    = r_tx_done;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboard bench for uart_tx_stream: pushed bytes queue expected frames, a line
// monitor decodes TXD and compares against the queued frames bit period by bit period.
module tb_uart_tx_stream;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en;
  logic       TXD;
  logic       busy;
  logic       tx_done;

  uart_tx_stream #(
    .CLK_FREQ(50_000_000),
    .BAUD    (5_000_000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .TXD       (TXD),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int   rd_cnt = 0;
  int   pushed = 0;
  logic last_rd = 1'b0;

  int   frames_done = 0;
  int   stray_done = 0;
  int   rd_err = 0;
  int   busy_err = 0;
  int   last_gap = 0;
  bit   mon_in_frame = 1'b0;
  int   mon_pos = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    fifo_empty = 1'b0;
    pushed++;
  endtask

  // One clock: the FIFO model pops on a sampled read request and presents data after the edge.
  task automatic tick();
    logic r;
    @(negedge clk);
    r = fifo_rd_en;
    last_rd = r;
    if (r === 1'b1) rd_cnt++;
    @(posedge clk);
    #1;
    if (r === 1'b1 && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic wait_frames(input int tgt, input int budget);
    int n = 0;
    while (frames_done < tgt && n < budget) begin
      tick();
      n++;
    end
    check("frames_done", frames_done, tgt);
  endtask

  // Line monitor / scoreboard consumer.
  logic fbits[NBITS];
  initial begin
    bit   in_frame = 0;
    bit   done_due = 0;
    bit   expect_gap = 0;
    int   gap_cnt = 0;
    int   pos = 0;
    logic bit_ok = 1'b1;
    logic bad_val = 1'b0;
    logic ebit;
    logic [7:0] b;
    int   ones;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (fifo_rd_en === 1'b1) rd_err++;
        in_frame = 0; done_due = 0; expect_gap = 0;
        mon_in_frame = 0; mon_pos = 0;
        continue;
      end
      if (fifo_rd_en === 1'b1 && (fifo_empty !== 1'b0 || busy !== 1'b0)) rd_err++;
      if (done_due) begin
        check("tx_done_pulse", tx_done, 1);
        done_due = 0;
        expect_gap = (fifo_empty === 1'b0);
      end else if (tx_done !== 1'b0) begin
        stray_done++;
      end
      if (!in_frame) begin
        if (TXD === 1'b0) begin
          if (expect_gap) check("b2b_gap", gap_cnt, 2);
          expect_gap = 0;
          last_gap = gap_cnt;
          check("frame_expected", exp_q.size() != 0, 1);
          b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
          ones = 0;
          fbits[0] = 1'b0;
          for (int k = 0; k < 8; k++) begin
            fbits[k+1] = b[k];
            ones += b[k];
          end
`ifdef UART_TX_PARITY_EN
          fbits[9]  = (ones % 2) == 1;
          fbits[10] = 1'b1;
`else
          fbits[9] = 1'b1;
`endif
          in_frame = 1; pos = 0; bit_ok = 1'b1;
        end else begin
          gap_cnt++;
          if (expect_gap && gap_cnt > 2) begin
            check("b2b_gap_late", gap_cnt, 2);
            expect_gap = 0;
          end
        end
      end
      if (in_frame) begin
        ebit = fbits[pos / CPB];
        if (TXD !== ebit) begin
          bit_ok = 1'b0;
          bad_val = TXD;
        end
        if (busy !== 1'b1) busy_err++;
        pos++;
        if (pos % CPB == 0) begin
          check($sformatf("frame%0d_bit%0d", frames_done, pos / CPB - 1),
                bit_ok ? ebit : bad_val, ebit);
          bit_ok = 1'b1;
        end
        if (pos == NBITS * CPB) begin
          in_frame = 0;
          frames_done++;
          done_due = 1;
          gap_cnt = 0;
        end
      end
      mon_in_frame = in_frame;
      mon_pos = pos;
    end
  end

  initial begin
    int base;
    int tgt;
    int n;
    int bad;
    push(8'hA5);
    repeat (3) begin
      tick();
      check("rst_txd", TXD, 1);
      check("rst_busy", busy, 0);
      check("rst_rd_en", last_rd, 0);
    end
    rst = 1'b0;

    base = rd_cnt;
    wait_frames(1, 400);
    repeat (3) tick();
    check("a5_rd_pulses", rd_cnt - base, 1);
    check("a5_busy_after", busy, 0);

    base = rd_cnt;
    push(8'h00);
    push(8'hFF);
    wait_frames(3, 600);
    check("b2b_last_gap", last_gap, 2);
    check("b2b_rd_pulses", rd_cnt - base, 2);

    push(8'h07);
    push(8'h03);
    wait_frames(5, 600);

    base = rd_cnt;
    tgt  = frames_done;
    push(8'h3C);
    n = 0;
    while (!(mon_in_frame && mon_pos >= 45) && n < 300) begin
      tick();
      n++;
    end
    check("abort_reached_mid_frame", n < 300, 1);
    rst = 1'b1;
    tick();
    check("abort_txd", TXD, 1);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    bad = 0;
    repeat (60) begin
      tick();
      if (tx_done !== 1'b0) bad++;
    end
    check("abort_no_done", bad, 0);
    check("abort_rd_pulses", rd_cnt - base, 1);
    check("abort_frames", frames_done, tgt);

    base = rd_cnt;
    bad = 0;
    repeat (1000) begin
      tick();
      if (TXD !== 1'b1) bad++;
    end
    check("idle_txd_high", bad, 0);
    check("idle_no_rd", rd_cnt - base, 0);

    tgt = frames_done;
    for (int i = 0; i < 20; i++) begin
      push(8'($urandom_range(0, 255)));
      tgt++;
      repeat ($urandom_range(0, 150)) tick();
    end
    wait_frames(tgt, 3000);
    repeat (5) tick();

    check("stray_tx_done", stray_done, 0);
    check("rd_en_illegal", rd_err, 0);
    check("busy_in_frame", busy_err, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    check("rd_total", rd_cnt, pushed);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
